// File: rtl/fft_seq_ctrl.sv
// Sequencer for the 256-point radix-2 DIT FFT: load, 8x128 butterfly issue with drain barriers, unload.
// Optional macro FFT_SEQ_INVERSE_EN adds the inverse input and the tw_conj output.
module fft_seq_ctrl #(
    parameter int BF_LAT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       load_start,
    input  logic       load_done,
    output logic       bf_valid,
    output logic [7:0] bf_x1_addr,
    output logic [7:0] bf_x2_addr,
    output logic [6:0] bf_tw_addr,
    output logic [2:0] bf_stage,
    output logic       out_start,
`ifdef FFT_SEQ_INVERSE_EN
    input  logic       out_done,
    input  logic       inverse,
    output logic       tw_conj
`else
    input  logic       out_done
`endif
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] CALC   = 3'd2;
    localparam logic [2:0] DRAIN  = 3'd3;
    localparam logic [2:0] UNLOAD = 3'd4;
    localparam logic [2:0] FIN    = 3'd5;

    localparam logic [3:0] DRAIN_LAST = 4'(BF_LAT - 1);

    logic [2:0] state_q, state_d;
    logic [2:0] s_q, s_d;
    logic [6:0] b_q, b_d;
    logic [3:0] drain_q, drain_d;

    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       load_start_q, load_start_d;
    logic       bf_valid_q, bf_valid_d;
    logic       out_start_q, out_start_d;
    logic [7:0] x1_q, x1_d;
    logic [7:0] x2_q, x2_d;
    logic [6:0] tw_q, tw_d;
    logic [2:0] stage_q, stage_d;

    logic [7:0] half_w;
    logic [6:0] j_w;
    logic [7:0] g_w;
    logic [7:0] x1_w;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        b_d     = b_q;
        drain_d = drain_q;
        case (state_q)
            IDLE:   if (start) state_d = LOAD;
            LOAD: begin
                if (load_done) begin
                    state_d = CALC;
                    s_d     = 3'd0;
                    b_d     = 7'd0;
                end
            end
            CALC: begin
                if (b_q == 7'd127) begin
                    state_d = DRAIN;
                    b_d     = 7'd0;
                    drain_d = 4'd0;
                end else begin
                    b_d = b_q + 7'd1;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    if (s_q == 3'd7) begin
                        state_d = UNLOAD;
                    end else begin
                        state_d = CALC;
                        s_d     = s_q + 3'd1;
                    end
                end else begin
                    drain_d = drain_q + 4'd1;
                end
            end
            UNLOAD: if (out_done) state_d = FIN;
            FIN: begin
                state_d = IDLE;
                s_d     = 3'd0;
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            s_d     = 3'd0;
            b_d     = 7'd0;
            drain_d = 4'd0;
        end
    end

    // Outputs are registered from the next state so each appears in the cycle its state begins.
    always_comb begin
        busy_d       = (state_d != IDLE);
        load_start_d = (state_d == LOAD);
        bf_valid_d   = (state_d == CALC);
        done_d       = (state_d == FIN);
        out_start_d  = (state_d == UNLOAD) && (state_q != UNLOAD);

        half_w = 8'd1 << s_d;
        j_w    = b_d & 7'(half_w - 8'd1);
        g_w    = {1'b0, b_d} >> s_d;
        x1_w   = (g_w << ({1'b0, s_d} + 4'd1)) | {1'b0, j_w};

        x1_d    = x1_q;
        x2_d    = x2_q;
        tw_d    = tw_q;
        stage_d = stage_q;
        if (state_d == CALC) begin
            x1_d    = x1_w;
            x2_d    = x1_w + half_w;
            tw_d    = j_w << (3'd7 - s_d);
            stage_d = s_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            s_q          <= 3'd0;
            b_q          <= 7'd0;
            drain_q      <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_start_q <= 1'b0;
            bf_valid_q   <= 1'b0;
            out_start_q  <= 1'b0;
            x1_q         <= 8'd0;
            x2_q         <= 8'd0;
            tw_q         <= 7'd0;
            stage_q      <= 3'd0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            b_q          <= b_d;
            drain_q      <= drain_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            load_start_q <= load_start_d;
            bf_valid_q   <= bf_valid_d;
            out_start_q  <= out_start_d;
            x1_q         <= x1_d;
            x2_q         <= x2_d;
            tw_q         <= tw_d;
            stage_q      <= stage_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign load_start = load_start_q;
    assign bf_valid   = bf_valid_q;
    assign out_start  = out_start_q;
    assign bf_x1_addr = x1_q;
    assign bf_x2_addr = x2_q;
    assign bf_tw_addr = tw_q;
    assign bf_stage   = stage_q;

`ifdef FFT_SEQ_INVERSE_EN
    // Transform direction is captured once per frame, at start acceptance.
    logic inv_q, inv_d;
    logic tw_conj_q, tw_conj_d;

    always_comb begin
        inv_d = inv_q;
        if (state_q == IDLE && state_d == LOAD) inv_d = inverse;
        tw_conj_d = (state_d != IDLE) ? inv_d : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inv_q     <= 1'b0;
            tw_conj_q <= 1'b0;
        end else begin
            inv_q     <= inv_d;
            tw_conj_q <= tw_conj_d;
        end
    end

    assign tw_conj = tw_conj_q;
`endif

endmodule
